// File: rtl/cpu_mem_loader.sv
// cpu_mem_loader: bring-up writer that fills data memory from a word stream.
// Frame format: start address, count N, then N data words. A frame with
// N == 0 terminates loading. The loader then keeps the core in reset for
// HOLD_CYCLES more cycles before releasing it.
//
// Handshake: a word transfers on a posedge where in_valid && in_ready.
// in_ready depends only on the registered FSM state, never on in_valid.
// The source may hold in_valid with stable data for as long as it likes.
// While HOLD or RUN is active, in_valid is ignored.
module cpu_mem_loader #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int HOLD_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWrData,
    output logic              memWrEn,
    output logic              coreReset,
    output logic              done,
    output logic              frame_err,
    output logic [2:0]        dbg_state_o
);

    localparam int HOLD_W = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYCLES);

    typedef enum logic [2:0] {
        S_ADDR  = 3'd0,
        S_COUNT = 3'd1,
        S_DATA  = 3'd2,
        S_HOLD  = 3'd3,
        S_RUN   = 3'd4
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   cnt_q;
    logic [HOLD_W-1:0]   hold_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wr_data_q;
    logic                mem_wr_en_q;
    logic                core_reset_q;
    logic                done_q;
    logic                frame_err_q;

    logic                accept_d;
    logic [ADDR_W-1:0]   addr_inc_d;
    logic                addr_wrap_d;

    // The stream is open only in the three loading states.
    assign in_ready    = (state_q == S_ADDR) || (state_q == S_COUNT) || (state_q == S_DATA);
    assign accept_d    = in_valid && in_ready;
    assign addr_inc_d  = addr_q + ADDR_W'(1);
    assign addr_wrap_d = &addr_q;

    assign memAddr     = mem_addr_q;
    assign memWrData   = mem_wr_data_q;
    assign memWrEn     = mem_wr_en_q;
    assign coreReset   = core_reset_q;
    assign done        = done_q;
    assign frame_err   = frame_err_q;
    assign dbg_state_o = state_q;

    // Loader FSM with registered write port, core reset and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_ADDR;
            addr_q        <= '0;
            cnt_q         <= '0;
            hold_q        <= '0;
            mem_addr_q    <= '0;
            mem_wr_data_q <= '0;
            mem_wr_en_q   <= 1'b0;
            core_reset_q  <= 1'b1;
            done_q        <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            // The write strobe lasts one cycle per accepted data word.
            mem_wr_en_q <= 1'b0;
            case (state_q)
                S_ADDR: begin
                    if (accept_d) begin
                        addr_q  <= ADDR_W'(in_data);
                        state_q <= S_COUNT;
                    end
                end
                S_COUNT: begin
                    if (accept_d) begin
                        if (in_data == '0) begin
                            hold_q  <= HOLD_INIT;
                            state_q <= S_HOLD;
                        end else begin
                            cnt_q   <= in_data;
                            state_q <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (accept_d) begin
                        mem_wr_en_q   <= 1'b1;
                        mem_addr_q    <= addr_q;
                        mem_wr_data_q <= in_data;
                        addr_q        <= addr_inc_d;
                        cnt_q         <= cnt_q - DATA_W'(1);
                        // Wrapping past the top of memory still writes, but it is flagged.
                        if (addr_wrap_d) begin
                            frame_err_q <= 1'b1;
                        end
                        if (cnt_q == DATA_W'(1)) begin
                            state_q <= S_ADDR;
                        end
                    end
                end
                S_HOLD: begin
                    // Core reset drops on the same edge that enters RUN.
                    if (hold_q == HOLD_W'(1)) begin
                        hold_q       <= '0;
                        core_reset_q <= 1'b0;
                        done_q       <= 1'b1;
                        state_q      <= S_RUN;
                    end else begin
                        hold_q <= hold_q - HOLD_W'(1);
                    end
                end
                S_RUN: begin
                    state_q <= S_RUN;
                end
                default: begin
                    state_q <= S_ADDR;
                end
            endcase
        end
    end

endmodule

// File: doc/cpu_mem_loader.md
Name: cpu_mem_loader

Overview:
- Bring-up writer that fills data memory from a 16-bit valid/ready word stream before the core runs.
- Holds the core in reset while loading. After a terminator frame it releases the core following a fixed reset-hold interval.
- Sits between the bench/host stream source and the dataMemory write port inside top, alongside the core.

Parameters:
DATA_W, 16, stream and memory data width
ADDR_W, 16, memory address width
HOLD_CYCLES, 4, cycles coreReset stays high after the terminator is accepted (pipeline flush); minimum 1

Ports:
clk  input  1  clock; all logic on posedge
reset  input  1  synchronous, active-high reset
in_data  input  DATA_W  stream word
in_valid  input  1  in_data valid
in_ready  output  1  loader can accept a word this cycle
memAddr  output  ADDR_W  data memory write address
memWrData  output  DATA_W  data memory write data
memWrEn  output  1  data memory write strobe, one cycle per word
coreReset  output  1  reset to core; high while loading or holding
done  output  1  high once the core has been released
frame_err  output  1  sticky: word count of a frame wrapped past address 0xFFFF

Behaviour:
- Handshake: a word is accepted on a posedge where in_valid && in_ready. in_valid may be held with stable data; in_ready is a pure function of the registered state.
- Frame format: word0 = start address, word1 = count N, then N data words.
- A frame with N == 0 is the terminator. Multiple data frames may precede it.
- States:
  - ADDR: in_ready=1; accept → latch addr_reg, go to COUNT.
  - COUNT: in_ready=1; accept N → if N==0 go to HOLD with hold counter = HOLD_CYCLES, else cnt_reg=N and go to DATA.
  - DATA: in_ready=1; each accept issues one write, addr_reg++, cnt_reg--; on the accept with cnt_reg==1 go to ADDR.
  - HOLD: in_ready=0; hold counter decrements each cycle; at 1 go to RUN.
  - RUN: in_ready=0, coreReset=0, done=1; stays in RUN until reset.
- Write timing: memAddr, memWrData and memWrEn are registered. memWrEn is high exactly the cycle after a DATA accept, with that word and its address. Back-to-back accepts give back-to-back writes, one per cycle, no bubbles.
- memWrEn is 0 in all other cycles. memAddr and memWrData hold their last value when memWrEn is 0.
- Address arithmetic: addr_reg is ADDR_W bits and wraps 0xFFFF → 0x0000.
  - A write after the wrap still occurs.
  - frame_err is set at the wrapping increment and stays set until reset.
- coreReset is registered:
  - 1 in ADDR/COUNT/DATA/HOLD.
  - Falls to 0 on the same edge that enters RUN, i.e. exactly HOLD_CYCLES cycles after the terminator-count accept edge.
- done is registered; it rises on that same edge.
- Reset values (also on reset mid-operation): state=ADDR, in_ready=1 from the first cycle after reset, memWrEn=0, memAddr=0, memWrData=0, coreReset=1, done=0, frame_err=0, counters 0.
- Reset mid-operation:
  - A partial frame is discarded. Words already written stay in memory; the loader does not clear them.
  - Reset in RUN re-asserts coreReset next cycle and reopens the stream.
- Simultaneous events: reset has priority over any handshake in the same cycle. in_valid is ignored in HOLD and RUN.

Test Plan:
- Single frame: stream 0x0001, 0x0003, 0x1111, 0x2222, 0x3333, then terminator 0x0000, 0x0000. Required: memWrEn pulses on 3 consecutive cycles with (addr,data) = (1,0x1111),(2,0x2222),(3,0x3333); coreReset falls exactly 4 cycles after the terminator count is accepted; done=1; mem[1]=0x1111.
- Throttled source: same stream with in_valid low on alternate cycles. Required: identical memory contents, one write per accepted word, no duplicate writes while in_valid is low.
- Two frames: (0x0010,2,0xAAAA,0xBBBB) then (0x0000,1,0xCCCC), then terminator. Required: mem[0x10]=0xAAAA, mem[0x11]=0xBBBB, mem[0]=0xCCCC; frame_err=0.
- Wrap: frame (0xFFFF,2,0x1234,0x5678). Required: writes (0xFFFF,0x1234) then (0x0000,0x5678); frame_err=1 and stays 1 after the terminator.
- Reset mid-DATA: frame (0x0020,4,…) with reset asserted after 2 data accepts. Required: only 0x20 and 0x21 written; in_ready=1 and state ADDR the cycle after reset; a new frame then loads correctly.
- Reset in RUN: after done=1, assert reset for 1 cycle. Required: coreReset=1, done=0 the next cycle; in_valid held during HOLD/RUN beforehand produced no writes.
